mem_bus_arbiter: RTL
====================

Name: mem_bus_arbiter

Overview:
Shares one single-ported memory bus between the core's instruction bus (ibus) and data bus (dbus). It sits between the pipeline's fetch/mem stages and the memory interconnect. It accepts one request at a time, registers it, forwards it downstream, and returns the response to the requester that owns it. Arbitration gives dbus priority, with an ibus starvation guard.

Parameters:
ADDR_W, 64, address width of all buses
DATA_W, 64, data width of all buses
STARVE_LIMIT, 4, number of consecutive dbus grants while ibus is waiting that forces the next grant to ibus (range 1..15)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous reset, active-low (0 = reset asserted)
i_valid  in  1  ibus request valid; held until i_data_ok
i_addr  in  ADDR_W  ibus fetch address
i_data_ok  out  1  one-cycle pulse: ibus transaction done, i_data valid
i_data  out  DATA_W  fetched word
d_valid  in  1  dbus request valid; held until d_data_ok
d_addr  in  ADDR_W  dbus address
d_size  in  3  access size code, passed through
d_strobe  in  DATA_W/8  byte write strobe; all-zero means read
d_wdata  in  DATA_W  store data
d_data_ok  out  1  one-cycle pulse: dbus transaction done
d_data  out  DATA_W  load data
m_valid  out  1  downstream request valid
m_addr  out  ADDR_W  registered request address
m_size  out  3  registered size (3'd3, i.e. 8 bytes, for ibus)
m_strobe  out  DATA_W/8  registered strobe (0 for ibus)
m_wdata  out  DATA_W  registered store data (0 for ibus)
m_ready  in  1  downstream completes request in this cycle
m_rdata  in  DATA_W  read data, valid when m_ready=1
starve_cnt  out  4  current ibus starvation counter (debug)

Behaviour:
- States: IDLE, GNT_I, GNT_D, RESP. Register the state; compute the next state combinationally.
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - All outputs go to 0: m_*, i_data_ok, d_data_ok, i_data, d_data, starve_cnt.
  - m_valid drops immediately, mid-transaction included. The in-flight transaction is abandoned and no data_ok is issued.
- IDLE arbitration, sampled at the clock edge:
  - Only d_valid: go to GNT_D.
  - Only i_valid: go to GNT_I.
  - Both valid: go to GNT_I if starve_cnt >= STARVE_LIMIT, else GNT_D.
  - Neither: stay in IDLE.
  - On the grant edge, latch the request fields into the m_* registers.
- GNT_x:
  - m_valid=1 and the m_* fields stay stable until m_ready.
  - Input changes on i_*/d_* are ignored while granted.
  - On an edge with m_ready=1: latch m_rdata into i_data or d_data, set the matching data_ok for exactly one cycle, clear m_valid, go to RESP.
- RESP:
  - data_ok is high during this cycle.
  - No new grant is made here, which prevents re-granting a requester whose valid has not yet dropped.
  - Always go to IDLE on the next edge; data_ok returns to 0.
- Latency: request sampled at edge t, so m_valid is high in cycle t+1. If m_ready=1 in cycle t+1, data_ok is high in cycle t+2. Minimum 3 cycles per transaction.
- i_data and d_data hold their last value until the next completion for that bus.
- starve_cnt, updated on grant edges only:
  - Increments (saturating at 15) on a GNT_D grant while i_valid=1.
  - Clears to 0 on any GNT_I grant.
  - Unchanged otherwise.
- Only one of i_data_ok / d_data_ok may be 1 in any cycle.
- m_ready while m_valid=0 is ignored.

Test Plan:
- Single ibus read: i_valid=1, i_addr=0x8000_0000, m_ready=1 in the first m_valid cycle, m_rdata=0x13 -> m_valid in cycle 1 with m_addr=0x8000_0000, m_strobe=0; i_data_ok pulse in cycle 2 with i_data=0x13; d_data_ok stays 0.
- Simultaneous request: i_valid=d_valid=1 in IDLE, starve_cnt=0 -> dbus granted first, m_addr=d_addr; after d_data_ok and RESP, ibus granted (starve_cnt was 1, now cleared).
- Starvation guard, STARVE_LIMIT=4: d_valid held high continuously (re-asserted each transaction) with i_valid=1 -> four dbus grants, starve_cnt reaches 4, fifth grant goes to ibus, starve_cnt returns to 0.
- Wait states: dbus store with d_strobe=0xFF, d_wdata=0xDEAD_BEEF, m_ready low for 5 cycles -> m_valid and m_* fields stable for all 6 cycles; a single d_data_ok pulse after m_ready.
- Reset mid-transaction: drive reset=0 during GNT_D -> m_valid drops in the same cycle without waiting for a clock edge; no data_ok issued; after reset=1 with i_valid=1, a clean ibus grant follows.
- RESP bubble: requester keeps i_valid=1 through its i_data_ok cycle -> no second grant in the RESP cycle; a new grant only after IDLE is re-entered.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// mem_bus_arbiter: single-outstanding ibus/dbus arbiter onto one memory bus, dbus priority with ibus starvation guard.
// Revision 1.0

module mem_bus_arbiter #(
  parameter int ADDR_W       = 64,
  parameter int DATA_W       = 64,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_valid,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic                i_data_ok,
  output logic [DATA_W-1:0]   i_data,
  input  logic                d_valid,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [2:0]          d_size,
  input  logic [DATA_W/8-1:0] d_strobe,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_data_ok,
  output logic [DATA_W-1:0]   d_data,
  output logic                m_valid,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [2:0]          m_size,
  output logic [DATA_W/8-1:0] m_strobe,
  output logic [DATA_W-1:0]   m_wdata,
  input  logic                m_ready,
  input  logic [DATA_W-1:0]   m_rdata,
  output logic [3:0]          starve_cnt
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GNT_I = 2'd1;
  localparam logic [1:0] GNT_D = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic       owner_d;
  logic       grant_i;
  logic       grant_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (d_valid && i_valid)
          state_nxt = (starve_cnt >= LIMIT) ? GNT_I : GNT_D;
        else if (d_valid)
          state_nxt = GNT_D;
        else if (i_valid)
          state_nxt = GNT_I;
      end
      GNT_I, GNT_D: if (m_ready) state_nxt = RESP;
      RESP:         state_nxt = IDLE;
      default:      state_nxt = IDLE;
    endcase
  end

  // Handshake outputs decode from state so an async reset clears them at once.
  always_comb begin
    m_valid   = (state == GNT_I) || (state == GNT_D);
    i_data_ok = (state == RESP) && !owner_d;
    d_data_ok = (state == RESP) && owner_d;
  end

  assign grant_i = (state == IDLE) && (state_nxt == GNT_I);
  assign grant_d = (state == IDLE) && (state_nxt == GNT_D);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_d    <= 1'b0;
      m_addr     <= '0;
      m_size     <= '0;
      m_strobe   <= '0;
      m_wdata    <= '0;
      i_data     <= '0;
      d_data     <= '0;
      starve_cnt <= '0;
    end else begin
      if (grant_d) begin
        owner_d  <= 1'b1;
        m_addr   <= d_addr;
        m_size   <= d_size;
        m_strobe <= d_strobe;
        m_wdata  <= d_wdata;
        if (i_valid && (starve_cnt != 4'd15))
          starve_cnt <= starve_cnt + 4'd1;
      end
      if (grant_i) begin
        owner_d    <= 1'b0;
        m_addr     <= i_addr;
        m_size     <= 3'd3;
        m_strobe   <= '0;
        m_wdata    <= '0;
        starve_cnt <= '0;
      end
      if ((state == GNT_I) && m_ready) i_data <= m_rdata;
      if ((state == GNT_D) && m_ready) d_data <= m_rdata;
    end
  end

endmodule

`default_nettype wire
